// File: rtl/eth_top_pkg.sv
// Shared Ethernet constants, FSM state type and header/length helpers for the frame generator.
package eth_top_pkg;

  localparam int ETH_HDR_BYTES   = 14;
  localparam int ETH_MIN_PAYLOAD = 46;
  localparam int ETH_MAX_PAYLOAD = 1500;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD
  } gen_state_t;

  // Byte idx of the 14-byte header, MSB-first: idx 0 is hdr[111:104].
  function automatic logic [7:0] hdr_byte(input logic [111:0] hdr, input logic [3:0] idx);
    logic [111:0] sh;
    sh = hdr << {idx, 3'b000};
    return sh[111:104];
  endfunction

  function automatic logic [10:0] clamp_len(input logic [10:0] len);
    if (len < 11'(ETH_MIN_PAYLOAD)) return 11'(ETH_MIN_PAYLOAD);
    else if (len > 11'(ETH_MAX_PAYLOAD)) return 11'(ETH_MAX_PAYLOAD);
    else return len;
  endfunction

endpackage

// File: rtl/eth_axis_frame_gen.sv
// AXIS Ethernet frame source: 14-byte L2 header then incrementing payload, one byte per beat.
// First beat one cycle after start; all outputs registered, beats hold while tready is low.
module eth_axis_frame_gen
  import eth_top_pkg::*;
#(
  parameter int DataWidth = 8,
  parameter int CntWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic [47:0]          dst_mac_i,
  input  logic [47:0]          src_mac_i,
  input  logic [15:0]          ethertype_i,
  input  logic [10:0]          payload_len_i,
  input  logic [7:0]           seed_i,
  input  logic [CntWidth-1:0]  num_frames_i,
  output logic [DataWidth-1:0] tx_axis_tdata_o,
  output logic                 tx_axis_tkeep_o,
  output logic                 tx_axis_tstrb_o,
  output logic                 tx_axis_tlast_o,
  output logic                 tx_axis_tuser_o,
  output logic                 tx_axis_tvalid_o,
  input  logic                 tx_axis_tready_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CntWidth-1:0]  frame_cnt_o
);

  gen_state_t          state_q, state_d;
  logic [10:0]         idx_q, idx_d;
  logic [111:0]        hdr_q, hdr_d;
  logic [10:0]         len_q, len_d;
  logic [7:0]          seed_q, seed_d;
  logic [CntWidth-1:0] num_q, num_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                stop_q, stop_d;
  logic [7:0]          tdata_q, tdata_d;
  logic                tlast_q, tlast_d;
  logic                tvalid_q, tvalid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                hs;
  logic [10:0]         idx_inc;
  logic [CntWidth-1:0] cnt_inc;
  logic                seq_end;

  assign hs      = tvalid_q & tx_axis_tready_i;
  assign idx_inc = idx_q + 11'd1;
  assign cnt_inc = cnt_q + 1'b1;
  assign seq_end = ((num_q != '0) && (cnt_inc == num_q)) || stop_q || stop_i;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    hdr_d    = hdr_q;
    len_d    = len_q;
    seed_d   = seed_q;
    num_d    = num_q;
    cnt_d    = cnt_q;
    stop_d   = stop_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A start coinciding with the done pulse belongs to the old sequence and is dropped.
        if (start_i && !done_q) begin
          hdr_d    = {dst_mac_i, src_mac_i, ethertype_i};
          len_d    = clamp_len(payload_len_i);
          seed_d   = seed_i;
          num_d    = num_frames_i;
          cnt_d    = '0;
          idx_d    = '0;
          stop_d   = 1'b0;
          tdata_d  = dst_mac_i[47:40];
          tlast_d  = 1'b0;
          tvalid_d = 1'b1;
          busy_d   = 1'b1;
          state_d  = ST_HDR;
        end
      end

      ST_HDR: begin
        if (stop_i) stop_d = 1'b1;
        if (hs) begin
          if (idx_q == 11'(ETH_HDR_BYTES - 1)) begin
            idx_d   = '0;
            tdata_d = seed_q;
            tlast_d = 1'b0;
            state_d = ST_PAYLOAD;
          end else begin
            idx_d   = idx_inc;
            tdata_d = hdr_byte(hdr_q, idx_inc[3:0]);
          end
        end
      end

      ST_PAYLOAD: begin
        if (stop_i) stop_d = 1'b1;
        if (hs) begin
          if (idx_q == len_q - 11'd1) begin
            cnt_d = cnt_inc;
            idx_d = '0;
            if (seq_end) begin
              tvalid_d = 1'b0;
              tdata_d  = '0;
              tlast_d  = 1'b0;
              busy_d   = 1'b0;
              done_d   = 1'b1;
              stop_d   = 1'b0;
              state_d  = ST_IDLE;
            end else begin
              tdata_d = hdr_q[111:104];
              tlast_d = 1'b0;
              state_d = ST_HDR;
            end
          end else begin
            idx_d   = idx_inc;
            tdata_d = seed_q + idx_inc[7:0];
            tlast_d = (idx_inc == len_q - 11'd1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      hdr_q    <= '0;
      len_q    <= 11'(ETH_MIN_PAYLOAD);
      seed_q   <= '0;
      num_q    <= '0;
      cnt_q    <= '0;
      stop_q   <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      hdr_q    <= hdr_d;
      len_q    <= len_d;
      seed_q   <= seed_d;
      num_q    <= num_d;
      cnt_q    <= cnt_d;
      stop_q   <= stop_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign tx_axis_tdata_o  = tdata_q;
  assign tx_axis_tkeep_o  = 1'b1;
  assign tx_axis_tstrb_o  = 1'b1;
  assign tx_axis_tuser_o  = 1'b0;
  assign tx_axis_tlast_o  = tlast_q;
  assign tx_axis_tvalid_o = tvalid_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign frame_cnt_o      = cnt_q;

endmodule
